// File: rtl/audio_note_pwm.sv
// rtl/audio_note_pwm.sv - square-wave note player driving the board AUD_PWM pin
// Optional feature macro: AUDIO_NOTE_PWM_TONE_GAP_EN (adds a silent GAP of GAP_CYCLES after each note)
module audio_note_pwm #(
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [17:0] note_half_period,
    input  logic [3:0]  note_beats,
    input  logic        stop,
    output logic        aud_pwm,
    output logic        busy
);

    // Longest note is 15 beats; the counter holds remaining cycles minus one.
    localparam int unsigned DUR_MAX = 15 * BEAT_CYCLES;
    localparam int unsigned DUR_W   = (DUR_MAX < 2) ? 1 : $clog2(DUR_MAX + 1);

`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1
    } state_t;

    // GAP_CYCLES has no effect in this build; tie it off so it is referenced.
    logic unused_gap_cfg;
    assign unused_gap_cfg = (GAP_CYCLES == 0);
`endif

    state_t            state_q, state_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [17:0]       tone_q, tone_d;
    logic [17:0]       half_q, half_d;
    logic              phase_q, phase_d;
    logic              ready_en_q, ready_en_d;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
    logic [GAP_W-1:0]  gap_q, gap_d;
`endif

    logic [DUR_W-1:0]  dur_load;
    logic              transfer;

    // Note length in cycles minus one, loaded when a note is accepted.
    assign dur_load = (DUR_W'(note_beats) * DUR_W'(BEAT_CYCLES)) - DUR_W'(1);

    // Handshake and status outputs; stop masks ready so no note slips in during an abort.
    assign note_ready = (state_q == IDLE) && ready_en_q && !stop;
    assign transfer   = note_valid && note_ready;
    assign busy       = (state_q != IDLE);
    assign aud_pwm    = (state_q == PLAY) && phase_q;

    // Next-state logic: handshake, duration countdown, tone phase and gap timing.
    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        tone_d     = tone_q;
        half_d     = half_q;
        phase_d    = phase_q;
        ready_en_d = 1'b1;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
        gap_d      = gap_q;
`endif
        if (stop) begin
            state_d = IDLE;
            dur_d   = '0;
            tone_d  = '0;
            half_d  = '0;
            phase_d = 1'b0;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
            gap_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero-beat note is consumed but never played.
                    if (transfer && (note_beats != 4'd0)) begin
                        state_d = PLAY;
                        half_d  = note_half_period;
                        dur_d   = dur_load;
                        tone_d  = (note_half_period != 18'd0) ? (note_half_period - 18'd1) : 18'd0;
                        phase_d = (note_half_period != 18'd0);
                    end
                end
                PLAY: begin
                    // Tone phase runs on its own; a rest (half period 0) never toggles.
                    if (half_q != 18'd0) begin
                        if (tone_q == 18'd0) begin
                            phase_d = ~phase_q;
                            tone_d  = half_q - 18'd1;
                        end else begin
                            tone_d  = tone_q - 18'd1;
                        end
                    end
                    // Duration may expire in the middle of a half period.
                    if (dur_q == '0) begin
                        tone_d  = '0;
                        half_d  = '0;
                        phase_d = 1'b0;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
                        if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(GAP_CYCLES - 1);
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        dur_d = dur_q - DUR_W'(1);
                    end
                end
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
                GAP: begin
                    if (gap_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    dur_d   = '0;
                    tone_d  = '0;
                    half_d  = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // State and counter registers; reset drops any note in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            tone_q     <= '0;
            half_q     <= '0;
            phase_q    <= 1'b0;
            ready_en_q <= 1'b0;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            tone_q     <= tone_d;
            half_q     <= half_d;
            phase_q    <= phase_d;
            ready_en_q <= ready_en_d;
`ifdef AUDIO_NOTE_PWM_TONE_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

endmodule

// File: doc/audio_note_pwm.md
AUDIO_NOTE_PWM -- requirements
Module: audio_note_pwm

Interface
- REQ-001 SHALL have parameter BEAT_CYCLES, default 12_500_000, giving clock cycles per beat (125 ms at 100 MHz).
- REQ-002 SHALL have parameter GAP_CYCLES, default 1_250_000, giving silent cycles after each note (used only with TONE_GAP_EN).
- REQ-003 SHALL have port clk, input, 1, the single 100 MHz system clock; all logic on its rising edge.
- REQ-004 SHALL have port rstn, input, 1, the asynchronous active-low reset.
- REQ-005 SHALL have port note_valid, input, 1, upstream note offered.
- REQ-006 SHALL have port note_ready, output, 1, block accepts the note this cycle.
- REQ-007 SHALL have port note_half_period, input, 18, square-wave half period in cycles; 0 = rest.
- REQ-008 SHALL have port note_beats, input, 4, note length in beats.
- REQ-009 SHALL have port stop, input, 1, synchronous abort of the current note.
- REQ-010 SHALL have port aud_pwm, output, 1, audio output to the board's AUD_PWM pin.
- REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
- REQ-012 SHALL implement states IDLE, PLAY and GAP; GAP exists only with TONE_GAP_EN.
- REQ-013 SHALL drive note_ready=1 only in IDLE; a transfer occurs on note_valid&&note_ready at a rising edge.
- REQ-014 SHALL register half period and beats on transfer; inputs are ignored outside a transfer.
- REQ-015 SHALL drop a transferred note with beats=0, stay in IDLE and keep note_ready=1.
- REQ-016 SHALL enter PLAY on the edge after a transfer with beats>0, with a duration of exactly beats*BEAT_CYCLES cycles.
- REQ-017 SHALL, in PLAY with half period P>0, drive aud_pwm=1 for the first P cycles, then toggle every P cycles; P=1 toggles every cycle.
- REQ-018 SHALL hold aud_pwm=0 for a rest note (P=0) while timing its duration normally.
- REQ-019 SHALL keep duration counting independent of the tone phase; a note may end mid half-period.
- REQ-020 SHALL drive aud_pwm=0 in IDLE and GAP.
- REQ-021 SHALL return to IDLE (or go to GAP) after the last PLAY cycle, giving at least one bubble cycle between notes.
- REQ-022 SHALL, when stop=1 in any state, go to IDLE at the next edge with aud_pwm=0 and all counters cleared.
- REQ-023 SHALL give stop priority over a simultaneous transfer; that note is not accepted and note_ready is forced to 0 while stop=1.
- REQ-024 SHALL use a duration counter wide enough for 15*BEAT_CYCLES with no wrap, and an 18-bit tone counter.

Reset
- REQ-025 SHALL, while rstn=0 and independent of clk, set the state to IDLE, clear all counters and the square phase, and drive aud_pwm=0, busy=0 and note_ready=0.
- REQ-026 SHALL assert note_ready=1 from the first rising clk edge after rstn deasserts.
- REQ-027 SHALL discard any note in progress when reset is asserted mid-note; it SHALL NOT resume.

Configuration
- REQ-028 SHALL use the macro AUDIO_NOTE_PWM_TONE_GAP_EN to control the gap feature.
- REQ-029 SHALL, with the macro defined, follow PLAY with GAP for exactly GAP_CYCLES cycles (aud_pwm=0, busy=1, note_ready=0), then return to IDLE; GAP_CYCLES=0 skips GAP.
- REQ-030 SHALL, without the macro, go from PLAY directly to IDLE, omit GAP logic and ignore GAP_CYCLES.

Verification (BEAT_CYCLES=10, GAP_CYCLES=3)
- REQ-031 SHALL cover a reset check: rstn pulsed low for 2 cycles mid-note -> aud_pwm=0, busy=0 immediately; note_ready=1 one cycle after release.
- REQ-032 SHALL cover a basic note: P=3, beats=2 -> aud_pwm 1,1,1,0,0,0,... for 20 cycles, busy high 20 cycles, then aud_pwm=0.
- REQ-033 SHALL cover a rest note: P=0, beats=1 -> aud_pwm=0 and busy=1 for 10 cycles.
- REQ-034 SHALL cover a zero-beat note: beats=0 offered -> accepted, busy never rises, next note accepted the following cycle.
- REQ-035 SHALL cover stop: stop asserted at cycle 5 of a P=2, beats=3 note -> aud_pwm=0, busy=0 next cycle; a valid note offered with stop is not taken.
- REQ-036 SHALL cover back-to-back notes: two notes (P=1, beats=1) -> with the macro, 10 PLAY + 3 GAP + 1 IDLE cycles before the second note's PLAY; without it, 10 PLAY + 1 IDLE.
